// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        KILL  = 2'd2,
        MISAL = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic isMisaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a fetched {instr, pc} pair while decode is stalled.
module fetch_skid_buffer #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic            i_flush,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    output logic            o_valid,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_pc
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            o_valid <= 1'b0;
        end else if (i_push) begin
            o_valid <= 1'b1;
        end else if (i_pop) begin
            o_valid <= 1'b0;
        end

        if (!i_rst_n) begin
            o_instr <= '0;
            o_pc    <= '0;
        end else if (i_push) begin
            o_instr <= i_instr;
            o_pc    <= i_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32 fetch stage: owns the PC, runs the held-request imem handshake and
// presents a registered IF/ID slot, with skid buffering and redirect squash.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imemReq,
    output logic [XLEN-1:0] o_imemAddr,
    input  logic            i_imemReady,
    input  logic [31:0]     i_imemRdata,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirectPC,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trapPC,
    input  logic            i_stallD,
    output logic            o_validD,
    output logic [31:0]     o_instrD,
    output logic [XLEN-1:0] o_pcD,
    output logic [XLEN-1:0] o_pcPlus4D,
    output logic            o_misalignD
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state;
    logic            runQ;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] killAddr;
    logic [XLEN-1:0] target;
    logic            flush;
    logic            memAcc;
    logic            skidValid;
    logic            skidPush;
    logic            skidPop;
    logic [31:0]     skidInstr;
    logic [XLEN-1:0] skidPc;

    // runQ keeps the request low for the first cycle out of reset.
    assign o_imemReq  = runQ && (state == FETCH || state == KILL);
    assign o_imemAddr = (state == KILL) ? killAddr : pc;
    assign flush      = i_trap | i_redirect;
    assign target     = i_trap ? i_trapPC : i_redirectPC;
    assign memAcc     = o_imemReq && i_imemReady && state == FETCH;
    assign skidPush   = memAcc && o_validD && i_stallD && !flush;
    assign skidPop    = state == FULL && !i_stallD && !flush;

    fetch_skid_buffer #(.XLEN(XLEN)) uSkid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (skidPush),
        .i_pop   (skidPop),
        .i_flush (flush),
        .i_instr (i_imemRdata),
        .i_pc    (pc),
        .o_valid (skidValid),
        .o_instr (skidInstr),
        .o_pc    (skidPc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= FETCH;
            runQ        <= 1'b0;
            pc          <= RESET_PC;
            killAddr    <= RESET_PC;
            o_validD    <= 1'b0;
            o_instrD    <= '0;
            o_pcD       <= '0;
            o_pcPlus4D  <= '0;
            o_misalignD <= 1'b0;
        end else begin
            runQ <= 1'b1;
            if (flush) begin
                pc          <= target;
                o_validD    <= 1'b0;
                o_misalignD <= 1'b0;
                case (state)
                    FETCH: begin
                        // An unanswered request must still complete at its old address.
                        if (o_imemReq && !i_imemReady) begin
                            state    <= KILL;
                            killAddr <= pc;
                        end else begin
                            state <= isMisaligned(target[1:0]) ? MISAL : FETCH;
                        end
                    end
                    KILL: begin
                        if (i_imemReady) state <= isMisaligned(target[1:0]) ? MISAL : FETCH;
                    end
                    default: state <= isMisaligned(target[1:0]) ? MISAL : FETCH;
                endcase
            end else begin
                case (state)
                    FETCH: begin
                        if (memAcc) begin
                            pc <= pc + PC_STEP;
                            if (o_validD && i_stallD) state <= FULL;
                        end
                    end
                    FULL: begin
                        if (!i_stallD) state <= FETCH;
                    end
                    KILL: begin
                        if (i_imemReady) state <= isMisaligned(pc[1:0]) ? MISAL : FETCH;
                    end
                    default: ;
                endcase

                if (state == MISAL) begin
                    o_validD    <= 1'b1;
                    o_misalignD <= 1'b1;
                    o_instrD    <= NOP_INSTR;
                    o_pcD       <= pc;
                    o_pcPlus4D  <= pc + PC_STEP;
                end else if (!i_stallD || !o_validD) begin
                    if (skidValid) begin
                        o_validD   <= 1'b1;
                        o_instrD   <= skidInstr;
                        o_pcD      <= skidPc;
                        o_pcPlus4D <= skidPc + PC_STEP;
                    end else if (memAcc) begin
                        o_validD   <= 1'b1;
                        o_instrD   <= i_imemRdata;
                        o_pcD      <= pc;
                        o_pcPlus4D <= pc + PC_STEP;
                    end else begin
                        o_validD <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios, then random traffic scored
// against an in-order expected-PC stream model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rstN;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] redirPC;
    logic        trap;
    logic [31:0] trapPC;
    logic        stall;
    logic        validD;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pc4;
    logic        mis;

    int nChk  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign rdata = memWord(addr);

    fetch_stage dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .o_imemReq    (req),
        .o_imemAddr   (addr),
        .i_imemReady  (ready),
        .i_imemRdata  (rdata),
        .i_redirect   (redir),
        .i_redirectPC (redirPC),
        .i_trap       (trap),
        .i_trapPC     (trapPC),
        .i_stallD     (stall),
        .o_validD     (validD),
        .o_instrD     (instrD),
        .o_pcD        (pcD),
        .o_pcPlus4D   (pc4),
        .o_misalignD  (mis)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChk++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [31:0] randTarget();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return ($urandom & 32'h0000_0FFC) | 32'h2;
        if (r == 1) return 32'hFFFF_FFF8;
        return $urandom & 32'h0000_0FFC;
    endfunction

    logic [31:0] expPc;
    logic        expMisal;
    logic        pReq;
    logic        pReady;
    logic [31:0] pAddr;
    int          nDeliv;

    initial begin
        rstN = 1'b0; ready = 1'b0; stall = 1'b0;
        redir = 1'b0; redirPC = '0; trap = 1'b0; trapPC = '0;
        repeat (2) @(posedge clk);
        smp();
        chk("rstReq", req, 0);    chk("rstAddr", addr, 0);  chk("rstValid", validD, 0);
        chk("rstInstr", instrD, 0); chk("rstPc", pcD, 0);   chk("rstPc4", pc4, 0);
        chk("rstMis", mis, 0);

        // Zero-wait streaming out of reset
        tick(); rstN = 1'b1; ready = 1'b1;
        smp(); chk("preReq", req, 0);
        tick(); smp();
        chk("c1Req", req, 1); chk("c1Addr", addr, 0); chk("c1Valid", validD, 0);
        tick(); smp();
        chk("c2Addr", addr, 4); chk("c2Valid", validD, 1); chk("c2Pc", pcD, 0);
        chk("c2Instr", instrD, memWord(0)); chk("c2Pc4", pc4, 4);
        tick(); smp();
        chk("c3Addr", addr, 8); chk("c3Pc", pcD, 4); chk("c3Instr", instrD, memWord(4));

        // Decode stall pushes one response into the skid buffer
        tick(); stall = 1'b1; smp();
        chk("s1Pc", pcD, 8); chk("s1Addr", addr, 12); chk("s1Req", req, 1);
        tick(); smp(); chk("s2Req", req, 0); chk("s2Pc", pcD, 8);
        tick(); smp(); chk("s3Req", req, 0); chk("s3Pc", pcD, 8);
        tick(); stall = 1'b0; smp(); chk("s4Req", req, 0); chk("s4Pc", pcD, 8);
        tick(); smp();
        chk("s5Pc", pcD, 12); chk("s5Instr", instrD, memWord(12)); chk("s5Addr", addr, 16);

        // Redirect during a delayed response: old address held, data dropped
        tick(); ready = 1'b0; redir = 1'b1; redirPC = 32'h100; smp();
        chk("k0Pc", pcD, 16); chk("k0Addr", addr, 20);
        tick(); redir = 1'b0; smp();
        chk("k1Addr", addr, 20); chk("k1Req", req, 1); chk("k1Valid", validD, 0);
        tick(); smp(); chk("k2Addr", addr, 20); chk("k2Valid", validD, 0);
        tick(); ready = 1'b1; smp(); chk("k3Addr", addr, 20); chk("k3Valid", validD, 0);
        tick(); smp(); chk("k4Addr", addr, 32'h100); chk("k4Valid", validD, 0);

        // Trap wins over a simultaneous redirect
        tick(); trap = 1'b1; trapPC = 32'h200; redir = 1'b1; redirPC = 32'h300; smp();
        chk("t0Pc", pcD, 32'h100); chk("t0Addr", addr, 32'h104);
        tick(); trap = 1'b0; redir = 1'b0; smp();
        chk("t1Addr", addr, 32'h200); chk("t1Valid", validD, 0);

        // Misaligned target parks in MISAL until a trap
        tick(); redir = 1'b1; redirPC = 32'h102; smp();
        chk("m0Pc", pcD, 32'h200); chk("m0Instr", instrD, memWord(32'h200));
        tick(); redir = 1'b0; smp(); chk("m1Req", req, 0); chk("m1Valid", validD, 0);
        tick(); smp();
        chk("m2Req", req, 0); chk("m2Valid", validD, 1); chk("m2Mis", mis, 1);
        chk("m2Pc", pcD, 32'h102); chk("m2Instr", instrD, 32'h13); chk("m2Pc4", pc4, 32'h106);
        tick(); stall = 1'b1; smp(); chk("m3Req", req, 0); chk("m3Pc", pcD, 32'h102);
        tick(); stall = 1'b0; trap = 1'b1; trapPC = 32'h200; smp();
        tick(); trap = 1'b0; smp();
        chk("m4Req", req, 1); chk("m4Addr", addr, 32'h200); chk("m4Mis", mis, 0);

        // Address wrap at the top of memory
        tick(); redir = 1'b1; redirPC = 32'hFFFF_FFFC; smp();
        tick(); redir = 1'b0; smp(); chk("w0Addr", addr, 32'hFFFF_FFFC);
        tick(); smp();
        chk("w1Addr", addr, 0); chk("w1Pc", pcD, 32'hFFFF_FFFC); chk("w1Pc4", pc4, 0);

        // Reset during an outstanding request abandons it
        tick(); ready = 1'b0; smp(); chk("r0Req", req, 1); chk("r0Addr", addr, 4);
        tick(); rstN = 1'b0; smp(); chk("r1Addr", addr, 4);
        tick(); smp();
        chk("r2Req", req, 0); chk("r2Addr", addr, 0); chk("r2Valid", validD, 0);
        tick(); rstN = 1'b1;

        // Random traffic against an in-order PC stream model
        expPc = 32'h0; expMisal = 1'b0; pReq = 1'b0; pReady = 1'b0; pAddr = '0; nDeliv = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            ready   = ($urandom_range(0, 1) == 1);
            stall   = ($urandom_range(0, 2) == 0);
            redir   = ($urandom_range(0, 11) == 0);
            trap    = ($urandom_range(0, 19) == 0);
            redirPC = randTarget();
            trapPC  = randTarget();
            smp();
            if (pReq && !pReady) begin
                chk("holdReq", req, 1);
                chk("holdAddr", addr, pAddr);
            end
            if (validD) begin
                if (expMisal) begin
                    chk("rMis", mis, 1); chk("rMisPc", pcD, expPc);
                    chk("rMisInstr", instrD, 32'h13); chk("rMisReq", req, 0);
                end else if (!stall && !redir && !trap) begin
                    chk("rPc", pcD, expPc); chk("rInstr", instrD, memWord(expPc));
                    chk("rPc4", pc4, expPc + 32'd4); chk("rMisLow", mis, 0);
                    expPc = expPc + 32'd4;
                    nDeliv++;
                end
            end
            if (trap) begin
                expPc = trapPC; expMisal = (trapPC[1:0] != 2'b00);
            end else if (redir) begin
                expPc = redirPC; expMisal = (redirPC[1:0] != 2'b00);
            end
            pReq = req; pReady = ready; pAddr = addr;
        end
        chk("progress", 32'(nDeliv > 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
